// File: rtl/seq_checker_if.sv
// Stream-checker bus: stimulus side (valid/data/clear) toward the checker,
// status side (lock, error strobe, counters, expected word) back out.
interface seq_checker_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             clear;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] rx_count;
   logic [WIDTH-1:0] expected;

   // Source / monitor side: drives the stream, observes the status.
   modport master (
      output in_valid, in_data, clear,
      input  locked, err_pulse, err_count, rx_count, expected
   );

   // Checker side.
   modport slave (
      input  in_valid, in_data, clear,
      output locked, err_pulse, err_count, rx_count, expected
   );
endinterface

// File: rtl/seq_checker.sv
// Receive-side checker for an incrementing test stream. Seeds on the first
// valid word, locks after LOCK_COUNT consecutive matches, counts errors while
// locked and drops lock after LOSS_COUNT consecutive mismatches.
module seq_checker #(
   parameter int WIDTH      = 8,
   parameter int CNT_W      = 16,
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3
) (
   input logic          CLK,
   input logic          RST,
   seq_checker_if.slave bus
);

   localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W = $clog2(LOSS_COUNT + 1);

   // Counter values that, on one more hit, reach the lock / loss threshold.
   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_COUNT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      HUNT,
      SYNC,
      LOCKED
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WIDTH-1:0]    r_expected;
   logic [WIDTH-1:0]    w_expected_nxt;
   logic [RUN_W-1:0]    r_run;
   logic [RUN_W-1:0]    w_run_nxt;
   logic [MISS_W-1:0]   r_miss;
   logic [MISS_W-1:0]   w_miss_nxt;
   logic                r_err_pulse;
   logic [CNT_W-1:0]    r_err_count;
   logic [CNT_W-1:0]    r_rx_count;
   logic                w_match;
   logic                w_err;
   logic [WIDTH-1:0]    w_data_inc;
   logic [WIDTH-1:0]    w_exp_inc;

   // Sequence arithmetic wraps modulo 2^WIDTH, so 0xFF -> 0x00 is a match.
   assign w_match    = (bus.in_data == r_expected);
   assign w_data_inc = bus.in_data + WIDTH'(1);
   assign w_exp_inc  = r_expected + WIDTH'(1);

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= HUNT;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic: seed in HUNT, count matches in SYNC, count misses in LOCKED.
   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned and infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      if (bus.in_valid) begin
         case (r_state)
            HUNT:    w_state_nxt = SYNC;
            SYNC:    if (w_match && r_run == RUN_LAST) w_state_nxt = LOCKED;
            LOCKED:  if (!w_match && r_miss == MISS_LAST) w_state_nxt = HUNT;
            default: w_state_nxt = HUNT;
         endcase
      end
   end

   // Output/datapath logic: next expected word, run/miss counters, error strobe.
   always_comb begin
      w_expected_nxt = r_expected;
      w_run_nxt      = r_run;
      w_miss_nxt     = r_miss;
      w_err          = 1'b0;
      if (bus.in_valid) begin
         case (r_state)
            HUNT: begin
               w_expected_nxt = w_data_inc;
               w_run_nxt      = '0;
               w_miss_nxt     = '0;
            end
            SYNC: begin
               w_miss_nxt = '0;
               if (w_match) begin
                  w_expected_nxt = w_exp_inc;
                  w_run_nxt      = r_run + RUN_W'(1);
               end else begin
                  // Reseed on the offending word; no error before lock.
                  w_expected_nxt = w_data_inc;
                  w_run_nxt      = '0;
               end
            end
            LOCKED: begin
               // Freewheel on a miss so one corrupted word costs one error.
               w_expected_nxt = w_exp_inc;
               if (w_match) begin
                  w_miss_nxt = '0;
               end else begin
                  w_err      = 1'b1;
                  w_miss_nxt = (r_miss == MISS_LAST) ? '0 : r_miss + MISS_W'(1);
               end
            end
            default: begin
               w_expected_nxt = r_expected;
            end
         endcase
      end
   end

   // Registered expected word, run/miss counters and error strobe.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_expected  <= '0;
         r_run       <= '0;
         r_miss      <= '0;
         r_err_pulse <= 1'b0;
      end else begin
         r_expected  <= w_expected_nxt;
         r_run       <= w_run_nxt;
         r_miss      <= w_miss_nxt;
         r_err_pulse <= w_err;
      end
   end

   // Saturating statistics counters; clear wins over a same-cycle increment.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_rx_count  <= '0;
         r_err_count <= '0;
      end else if (bus.clear) begin
         r_rx_count  <= '0;
         r_err_count <= '0;
      end else begin
         if (bus.in_valid && r_rx_count != CNT_MAX) r_rx_count <= r_rx_count + CNT_W'(1);
         if (w_err && r_err_count != CNT_MAX)      r_err_count <= r_err_count + CNT_W'(1);
      end
   end

   assign bus.locked    = (r_state == LOCKED);
   assign bus.err_pulse = r_err_pulse;
   assign bus.err_count = r_err_count;
   assign bus.rx_count  = r_rx_count;
   assign bus.expected  = r_expected;

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: table of stimulus/expected records
// applied through a scoreboard queue, plus hand-written async-reset sequence.
// A second instance with 3-bit counters shares the stimulus to exercise
// counter saturation.
module tb_seq_checker;

   logic clk;
   logic rst;

   seq_checker_if #(.WIDTH(8), .CNT_W(16)) bus ();
   seq_checker_if #(.WIDTH(8), .CNT_W(3))  sat_bus ();

   seq_checker #(.WIDTH(8), .CNT_W(16), .LOCK_COUNT(4), .LOSS_COUNT(3)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   seq_checker #(.WIDTH(8), .CNT_W(3), .LOCK_COUNT(4), .LOSS_COUNT(3)) dut_sat (
      .CLK (clk),
      .RST (rst),
      .bus (sat_bus)
   );

   assign sat_bus.in_valid = bus.in_valid;
   assign sat_bus.in_data  = bus.in_data;
   assign sat_bus.clear    = bus.clear;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst_before;
      bit          valid;
      logic [7:0]  data;
      bit          clr;
      bit          locked;
      bit          pulse;
      logic [15:0] errc;
      logic [15:0] rxc;
      logic [7:0]  expd;
   } vec_t;

   vec_t vecs[$];
   vec_t sb_q[$];

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit rb, input bit v, input logic [7:0] d, input bit c,
                               input bit l, input bit p, input int e, input int r,
                               input logic [7:0] x);
      vec_t t;
      t.rst_before = rb;
      t.valid      = v;
      t.data       = d;
      t.clr        = c;
      t.locked     = l;
      t.pulse      = p;
      t.errc       = 16'(e);
      t.rxc        = 16'(r);
      t.expd       = x;
      return t;
   endfunction

   task automatic do_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.clear    = 1'b0;
      #50;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Drive one record, queue its expectation, compare after the next edge.
   task automatic apply_vec(input vec_t v, input int idx);
      vec_t e;
      logic [2:0] sat_exp;
      if (v.rst_before) do_reset();
      @(negedge clk);
      bus.in_valid = v.valid;
      bus.in_data  = v.data;
      bus.clear    = v.clr;
      sb_q.push_back(v);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check($sformatf("v%0d locked", idx),    32'(bus.locked),    32'(e.locked));
      check($sformatf("v%0d err_pulse", idx), 32'(bus.err_pulse), 32'(e.pulse));
      check($sformatf("v%0d err_count", idx), 32'(bus.err_count), 32'(e.errc));
      check($sformatf("v%0d rx_count", idx),  32'(bus.rx_count),  32'(e.rxc));
      check($sformatf("v%0d expected", idx),  32'(bus.expected),  32'(e.expd));
      sat_exp = (e.rxc > 16'd7) ? 3'd7 : e.rxc[2:0];
      check($sformatf("v%0d sat rx_count", idx), 32'(sat_bus.rx_count), 32'(sat_exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t t;

      // Reset and lock on 0x10..0x14.
      vecs.push_back(mk(0, 1, 8'h10, 0, 0, 0, 0, 1, 8'h11));
      vecs.push_back(mk(0, 1, 8'h11, 0, 0, 0, 0, 2, 8'h12));
      vecs.push_back(mk(0, 1, 8'h12, 0, 0, 0, 0, 3, 8'h13));
      vecs.push_back(mk(0, 1, 8'h13, 0, 0, 0, 0, 4, 8'h14));
      vecs.push_back(mk(0, 1, 8'h14, 0, 1, 0, 0, 5, 8'h15));
      // Wrap-around through 0xFF -> 0x00.
      vecs.push_back(mk(1, 1, 8'hF8, 0, 0, 0, 0, 1, 8'hF9));
      vecs.push_back(mk(0, 1, 8'hF9, 0, 0, 0, 0, 2, 8'hFA));
      vecs.push_back(mk(0, 1, 8'hFA, 0, 0, 0, 0, 3, 8'hFB));
      vecs.push_back(mk(0, 1, 8'hFB, 0, 0, 0, 0, 4, 8'hFC));
      vecs.push_back(mk(0, 1, 8'hFC, 0, 1, 0, 0, 5, 8'hFD));
      vecs.push_back(mk(0, 1, 8'hFD, 0, 1, 0, 0, 6, 8'hFE));
      vecs.push_back(mk(0, 1, 8'hFE, 0, 1, 0, 0, 7, 8'hFF));
      vecs.push_back(mk(0, 1, 8'hFF, 0, 1, 0, 0, 8, 8'h00));
      vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 9, 8'h01));
      vecs.push_back(mk(0, 1, 8'h01, 0, 1, 0, 0, 10, 8'h02));
      // Single corruption while locked.
      vecs.push_back(mk(1, 1, 8'h1B, 0, 0, 0, 0, 1, 8'h1C));
      vecs.push_back(mk(0, 1, 8'h1C, 0, 0, 0, 0, 2, 8'h1D));
      vecs.push_back(mk(0, 1, 8'h1D, 0, 0, 0, 0, 3, 8'h1E));
      vecs.push_back(mk(0, 1, 8'h1E, 0, 0, 0, 0, 4, 8'h1F));
      vecs.push_back(mk(0, 1, 8'h1F, 0, 1, 0, 0, 5, 8'h20));
      vecs.push_back(mk(0, 1, 8'h20, 0, 1, 0, 0, 6, 8'h21));
      vecs.push_back(mk(0, 1, 8'h21, 0, 1, 0, 0, 7, 8'h22));
      vecs.push_back(mk(0, 1, 8'h55, 0, 1, 1, 1, 8, 8'h23));
      vecs.push_back(mk(0, 1, 8'h23, 0, 1, 0, 1, 9, 8'h24));
      vecs.push_back(mk(0, 1, 8'h24, 0, 1, 0, 1, 10, 8'h25));
      // Loss after three misses, then relock on 0x80..0x84.
      vecs.push_back(mk(1, 1, 8'h3B, 0, 0, 0, 0, 1, 8'h3C));
      vecs.push_back(mk(0, 1, 8'h3C, 0, 0, 0, 0, 2, 8'h3D));
      vecs.push_back(mk(0, 1, 8'h3D, 0, 0, 0, 0, 3, 8'h3E));
      vecs.push_back(mk(0, 1, 8'h3E, 0, 0, 0, 0, 4, 8'h3F));
      vecs.push_back(mk(0, 1, 8'h3F, 0, 1, 0, 0, 5, 8'h40));
      vecs.push_back(mk(0, 1, 8'h00, 0, 1, 1, 1, 6, 8'h41));
      vecs.push_back(mk(0, 1, 8'h00, 0, 1, 1, 2, 7, 8'h42));
      vecs.push_back(mk(0, 1, 8'h00, 0, 0, 1, 3, 8, 8'h43));
      vecs.push_back(mk(0, 1, 8'h80, 0, 0, 0, 3, 9, 8'h81));
      vecs.push_back(mk(0, 1, 8'h81, 0, 0, 0, 3, 10, 8'h82));
      vecs.push_back(mk(0, 1, 8'h82, 0, 0, 0, 3, 11, 8'h83));
      vecs.push_back(mk(0, 1, 8'h83, 0, 0, 0, 3, 12, 8'h84));
      vecs.push_back(mk(0, 1, 8'h84, 0, 1, 0, 3, 13, 8'h85));
      // Valid gaps and clear.
      vecs.push_back(mk(1, 1, 8'h2B, 0, 0, 0, 0, 1, 8'h2C));
      vecs.push_back(mk(0, 1, 8'h2C, 0, 0, 0, 0, 2, 8'h2D));
      vecs.push_back(mk(0, 1, 8'h2D, 0, 0, 0, 0, 3, 8'h2E));
      vecs.push_back(mk(0, 1, 8'h2E, 0, 0, 0, 0, 4, 8'h2F));
      vecs.push_back(mk(0, 1, 8'h2F, 0, 1, 0, 0, 5, 8'h30));
      vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h30));
      vecs.push_back(mk(0, 1, 8'h30, 0, 1, 0, 0, 1, 8'h31));
      vecs.push_back(mk(0, 0, 8'hAA, 0, 1, 0, 0, 1, 8'h31));
      vecs.push_back(mk(0, 1, 8'h31, 0, 1, 0, 0, 2, 8'h32));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 2, 8'h32));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 2, 8'h32));
      vecs.push_back(mk(0, 1, 8'h32, 0, 1, 0, 0, 3, 8'h33));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 3, 8'h33));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 3, 8'h33));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 3, 8'h33));
      vecs.push_back(mk(0, 1, 8'h99, 1, 1, 1, 0, 0, 8'h34));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h34));

      // Power-on reset and reset-state checks.
      do_reset();
      #1;
      check("reset locked",    32'(bus.locked),    32'd0);
      check("reset err_pulse", 32'(bus.err_pulse), 32'd0);
      check("reset err_count", 32'(bus.err_count), 32'd0);
      check("reset rx_count",  32'(bus.rx_count),  32'd0);
      check("reset expected",  32'(bus.expected),  32'd0);

      for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

      // Async reset mid-lock: outputs must clear before the next edge.
      check("pre-reset locked", 32'(bus.locked), 32'd1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async locked",    32'(bus.locked),    32'd0);
      check("async err_pulse", 32'(bus.err_pulse), 32'd0);
      check("async err_count", 32'(bus.err_count), 32'd0);
      check("async rx_count",  32'(bus.rx_count),  32'd0);
      check("async expected",  32'(bus.expected),  32'd0);
      bus.in_valid = 1'b0;
      bus.clear    = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Relock on 0x07..0x0B after the async reset.
      for (int i = 0; i < 5; i++) begin
         t = mk(0, 1, 8'(7 + i), 0, (i == 4), 0, 0, i + 1, 8'(8 + i));
         apply_vec(t, 100 + i);
      end

      if (sb_q.size() != 0) begin
         n_miss++;
         $display("FAIL scoreboard drain: %0d entries left, want 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
